prco_uart_loader: RTL

//  UART boot loader that sits upstream of prco_core: receives a framed program image over
//  a serial line, writes it word-by-word into the core's instruction memory, and holds the

---
 rtl/prco_uart_loader_if.sv | 33 +++
 rtl/prco_uart_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prco_uart_loader_if.sv
// Instruction-memory write bus and loader status seen by prco_core.
// The loader drives everything (master); the core/memory side observes (slave).
interface prco_uart_loader_if #(
    parameter int ADDR_W = 8
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              core_rst;
    logic              busy;
    logic              err;
    logic [ADDR_W:0]   word_count;

    modport master (
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output core_rst,
        output busy,
        output err,
        output word_count
    );

    modport slave (
        input mem_we,
        input mem_addr,
        input mem_wdata,
        input core_rst,
        input busy,
        input err,
        input word_count
    );
endinterface

// File: rtl/prco_uart_loader.sv
// UART boot loader for prco_core.
// Receives a frame (0xA5, N, N big-endian 16-bit words, XOR checksum) over an
// 8N1 serial line, writes each word into instruction memory and releases the
// core from reset only after a complete image with a matching checksum.
module prco_uart_loader #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200,
    parameter int ADDR_W = 8
) (
    input  logic                clk50,
    input  logic                rst,
    input  logic                uart_rx,
    prco_uart_loader_if.master  bus
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;
    localparam int MAX_WORDS    = 2 ** ADDR_W;
    localparam int SYNC_LEN     = 3;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0]       HDR       = 8'hA5;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_HI,
        S_LO,
        S_CSUM,
        S_DONE,
        S_ERR
    } ld_state_t;

    // ------------------------------------------------------------------
    // Input synchroniser. Stages 0/1 are the two-flop synchroniser; stage 2
    // only remembers the previous synced value for falling-edge detection.
    // ------------------------------------------------------------------
    logic [SYNC_LEN-1:0] sync_reg;
    logic [SYNC_LEN-1:0] sync_next;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_LEN; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = uart_rx;
            end else begin : g_chain
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    // Shift the line through the synchroniser; idle-high after reset.
    always_ff @(posedge clk50) begin
        if (rst) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= sync_next;
        end
    end

    logic rx_s;
    logic rx_fall;
    assign rx_s    = sync_reg[1];
    assign rx_fall = sync_reg[2] & ~sync_reg[1];

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    rx_state_t        rx_state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       bit_idx_reg;
    logic [7:0]       shift_reg;

    // Byte strobes are taken in the stop-bit sample cycle itself, so the
    // loader can register its response on that same edge.
    logic       stop_sample;
    logic       byte_valid;
    logic       frame_err;
    logic [7:0] rx_byte;
    assign stop_sample = (rx_state_reg == RX_STOP) && (cnt_reg == BIT_LAST);
    assign byte_valid  = stop_sample & rx_s;
    assign frame_err   = stop_sample & ~rx_s;
    assign rx_byte     = shift_reg;

    // Receiver FSM: start-bit qualification, 8 LSB-first data samples, stop sample.
    always_ff @(posedge clk50) begin
        if (rst) begin
            rx_state_reg <= RX_IDLE;
            cnt_reg      <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
        end else begin
            case (rx_state_reg)
                RX_IDLE: begin
                    cnt_reg <= '0;
                    if (rx_fall) begin
                        rx_state_reg <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt_reg == HALF_LAST) begin
                        cnt_reg     <= '0;
                        bit_idx_reg <= '0;
                        // A start bit that is high again mid-bit was a glitch.
                        rx_state_reg <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_reg   <= '0;
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        if (bit_idx_reg == 3'd7) begin
                            rx_state_reg <= RX_STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_reg      <= '0;
                        rx_state_reg <= RX_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: rx_state_reg <= RX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Loader
    // ------------------------------------------------------------------
    ld_state_t         state_reg;
    logic [7:0]        len_reg;
    logic [7:0]        hi_reg;
    logic [7:0]        csum_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [15:0]       mem_wdata_reg;
    logic              core_rst_reg;
    logic              busy_reg;
    logic              err_reg;
    logic [ADDR_W:0]   word_count_reg;

    // Loader FSM: steps only on a received byte or a framing error.
    always_ff @(posedge clk50) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            len_reg        <= '0;
            hi_reg         <= '0;
            csum_reg       <= '0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            core_rst_reg   <= 1'b1;
            busy_reg       <= 1'b0;
            err_reg        <= 1'b0;
            word_count_reg <= '0;
        end else begin
            mem_we_reg <= 1'b0;
            if (frame_err) begin
                // A broken byte outside a frame is just line noise.
                if (state_reg != S_IDLE && state_reg != S_DONE) begin
                    state_reg    <= S_ERR;
                    err_reg      <= 1'b1;
                    busy_reg     <= 1'b0;
                    core_rst_reg <= 1'b1;
                end
            end else if (byte_valid) begin
                case (state_reg)
                    S_IDLE, S_DONE, S_ERR: begin
                        if (rx_byte == HDR) begin
                            state_reg      <= S_LEN;
                            busy_reg       <= 1'b1;
                            err_reg        <= 1'b0;
                            word_count_reg <= '0;
                            csum_reg       <= '0;
                            core_rst_reg   <= 1'b1;
                        end
                    end
                    S_LEN: begin
                        len_reg <= rx_byte;
                        if (rx_byte == 8'd0) begin
                            state_reg <= S_CSUM;
                        end else if (int'(rx_byte) > MAX_WORDS) begin
                            state_reg    <= S_ERR;
                            err_reg      <= 1'b1;
                            busy_reg     <= 1'b0;
                            core_rst_reg <= 1'b1;
                        end else begin
                            state_reg <= S_HI;
                        end
                    end
                    S_HI: begin
                        hi_reg    <= rx_byte;
                        csum_reg  <= csum_reg ^ rx_byte;
                        state_reg <= S_LO;
                    end
                    S_LO: begin
                        csum_reg       <= csum_reg ^ rx_byte;
                        mem_we_reg     <= 1'b1;
                        mem_addr_reg   <= word_count_reg[ADDR_W-1:0];
                        mem_wdata_reg  <= {hi_reg, rx_byte};
                        word_count_reg <= word_count_reg + 1'b1;
                        if (int'(word_count_reg) + 1 == int'(len_reg)) begin
                            state_reg <= S_CSUM;
                        end else begin
                            state_reg <= S_HI;
                        end
                    end
                    S_CSUM: begin
                        busy_reg <= 1'b0;
                        if (rx_byte == csum_reg) begin
                            state_reg    <= S_DONE;
                            core_rst_reg <= 1'b0;
                        end else begin
                            state_reg    <= S_ERR;
                            err_reg      <= 1'b1;
                            core_rst_reg <= 1'b1;
                        end
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.mem_we     = mem_we_reg;
    assign bus.mem_addr   = mem_addr_reg;
    assign bus.mem_wdata  = mem_wdata_reg;
    assign bus.core_rst   = core_rst_reg;
    assign bus.busy       = busy_reg;
    assign bus.err        = err_reg;
    assign bus.word_count = word_count_reg;

endmodule
